// File: rtl/ysyx_pipe_pkg.sv
// Shared types for the pipeline decoupling queues: stage payload structs
// and the explicit-wrap pointer increment used by the FIFO control.
package ysyx_pipe_pkg;

   localparam int unsigned YSYX_XLEN     = 32;
   localparam int unsigned YSYX_ROB_SIZE = 8;
   localparam int unsigned YSYX_ROB_W    = $clog2(YSYX_ROB_SIZE);

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_SLT, ALU_SLTU, ALU_LUI, ALU_NOP
   } alu_op_e;

   // Decode -> issue payload
   typedef struct packed {
      alu_op_e                alu_op;
      logic                   jen;
      logic                   ben;
      logic                   wen;
      logic                   ren;
      logic                   ebreak;
      logic                   ecall;
      logic                   mret;
      logic [1:0]             csr_csw;
      logic [4:0]             rd;
      logic [YSYX_XLEN-1:0]   imm;
      logic [YSYX_XLEN-1:0]   op1;
      logic [YSYX_XLEN-1:0]   op2;
      logic [4:0]             rs1;
      logic [4:0]             rs2;
      logic [YSYX_ROB_W-1:0]  qj;
      logic [YSYX_ROB_W-1:0]  qk;
      logic [YSYX_ROB_W-1:0]  dest;
      logic [YSYX_XLEN-1:0]   pnpc;
      logic [YSYX_XLEN-1:0]   inst;
      logic [YSYX_XLEN-1:0]   pc;
   } idu_pipe_t;

   // Execute -> ROB payload
   typedef struct packed {
      logic [YSYX_XLEN-1:0]   result;
      logic [YSYX_XLEN-1:0]   npc;
      logic                   pc_change;
      logic                   csr_wen;
      logic [11:0]            csr_addr;
      logic [YSYX_XLEN-1:0]   csr_wdata;
      logic [YSYX_ROB_W-1:0]  dest;
      logic [YSYX_XLEN-1:0]   pc;
   } exu_pipe_t;

   // Pointers live in [0, depth-1]; wrap explicitly so non-power-of-two depths work
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/ysyx_pipe_fifo_ram.sv
// FIFO storage: DEPTH x W, one write port, one asynchronous read port.
// Kept separate so a target-specific memory can be dropped in.
module ysyx_pipe_fifo_ram #(
   parameter int unsigned W     = 128,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 2
) (
   input  logic          clock_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   // Storage is intentionally not reset; control logic never exposes stale entries
   always_ff @(posedge clock_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ysyx_pipe_fifo.sv
// Valid/ready decoupling queue between pipeline stages with optional
// empty-bypass and synchronous flush on redirect.
module ysyx_pipe_fifo
   import ysyx_pipe_pkg::*;
#(
   parameter int unsigned W      = 128,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned BYPASS = 0
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [W-1:0]               in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [W-1:0]               out_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [CW-1:0] count_q, count_d;

   logic          empty, full, bypassActive;
   logic          enq, deq, passThrough, doWrite, doPop;
   logic [W-1:0]  ramRdata;

   assign empty        = (count_q == '0);
   assign full         = (count_q == CW'(DEPTH));
   assign bypassActive = (BYPASS != 0) && empty;

   // in_ready depends only on registered occupancy, never on out_ready
   assign in_ready  = !full;
   assign out_valid = !flush && (bypassActive ? in_valid : !empty);
   assign out_data  = bypassActive ? in_data : ramRdata;
   assign count     = count_q;

   assign enq         = in_valid && in_ready && !flush;
   assign deq         = out_valid && out_ready && !flush;
   assign passThrough = bypassActive && enq && deq;
   assign doWrite     = enq && !passThrough;
   assign doPop       = deq && !passThrough;

   // Next-state for pointers and occupancy; flush squashes everything
   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      if (flush) begin
         rdPtr_d = '0;
         wrPtr_d = '0;
         count_d = '0;
      end else begin
         if (doWrite) begin
            wrPtr_d = PW'(ptr_inc(32'(wrPtr_q), DEPTH));
         end
         if (doPop) begin
            rdPtr_d = PW'(ptr_inc(32'(rdPtr_q), DEPTH));
         end
         case ({doWrite, doPop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register, cleared asynchronously
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
      end
   end

   ysyx_pipe_fifo_ram #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_ram (
      .clock_i (clock),
      .we_i    (doWrite),
      .waddr_i (wrPtr_q),
      .wdata_i (in_data),
      .raddr_i (rdPtr_q),
      .rdata_o (ramRdata)
   );

`ifndef SYNTHESIS
   // Simulation-only sanity checks on occupancy and handshake legality
   always @(posedge clock) begin
      if (reset) begin
         assert (count_q <= CW'(DEPTH));
         assert (!(enq && full));
         assert (!(doPop && empty));
      end
   end
`endif

endmodule
